// File: rtl/regfile_sp_pkg.sv
// Shared encodings and default constants for the register file and its stack-pointer unit.
// The stack controller and the memory stage both import these values.
package regfile_sp_pkg;

    localparam logic SP_OP_PUSH = 1'b0;
    localparam logic SP_OP_POP  = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    localparam logic [DEF_DATA_W-1:0] DEF_SP_RESET = 8'hFE;
    localparam logic [DEF_DATA_W-1:0] DEF_SP_LIMIT = 8'h80;

    // Outcome of a stack request in the current cycle.
    typedef enum logic [1:0] {
        SP_EV_NONE,
        SP_EV_MOVE,
        SP_EV_OVF,
        SP_EV_UNF
    } sp_event_e;

endpackage

// File: rtl/regfile_sp_if.sv
// Bus bundle for regfile_sp: decode read ports, writeback write port and the stack path.
interface regfile_sp_if
    import regfile_sp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sp_en;
    logic              sp_op;
    logic [DATA_W-1:0] sp_out;
    logic [DATA_W-1:0] raw_sp;
    logic [DATA_W-1:0] sp_addr;
    logic [DATA_W-1:0] stack_depth;
    logic              sp_ovf;
    logic              sp_unf;
    logic              err_clr;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sp_en, sp_op, err_clr,
        input  rd_data_a, rd_data_b, sp_out, raw_sp, sp_addr, stack_depth, sp_ovf, sp_unf
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, sp_en, sp_op, err_clr,
        output rd_data_a, rd_data_b, sp_out, raw_sp, sp_addr, stack_depth, sp_ovf, sp_unf
    );

endinterface

// File: rtl/regfile_sp_sp_unit.sv
// Stack-pointer unit: next-SP computation with bound checks, sticky error flags,
// stack memory address and live stack depth.
module sp_unit
    import regfile_sp_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(DEF_SP_RESET),
    parameter logic [DATA_W-1:0] SP_LIMIT = DATA_W'(DEF_SP_LIMIT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_raw_sp,
    input  logic              i_sp_en,
    input  logic              i_sp_op,
    input  logic              i_sp_blocked,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_sp_next,
    output logic              o_sp_upd,
    output logic [DATA_W-1:0] o_sp_addr,
    output logic [DATA_W-1:0] o_stack_depth,
    output logic              o_sp_ovf,
    output logic              o_sp_unf
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    sp_event_e w_event;
    logic      r_ovf;
    logic      r_unf;

    // Bounds are tested on the registered SP before any arithmetic, so a checked op never wraps.
    always_comb begin
        w_event   = SP_EV_NONE;
        o_sp_next = i_raw_sp;
        if (i_sp_en && !i_sp_blocked) begin
            if (i_sp_op == SP_OP_PUSH) begin
                if (i_raw_sp == SP_LIMIT) begin
                    w_event = SP_EV_OVF;
                end else begin
                    w_event   = SP_EV_MOVE;
                    o_sp_next = i_raw_sp - ONE;
                end
            end else begin
                if (i_raw_sp == SP_RESET) begin
                    w_event = SP_EV_UNF;
                end else begin
                    w_event   = SP_EV_MOVE;
                    o_sp_next = i_raw_sp + ONE;
                end
            end
        end
    end

    assign o_sp_upd = (w_event == SP_EV_MOVE);

    // A fresh error outranks a clear issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_event == SP_EV_OVF) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_event == SP_EV_UNF) begin
                r_unf <= 1'b1;
            end else if (i_err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign o_sp_ovf      = r_ovf;
    assign o_sp_unf      = r_unf;
    assign o_sp_addr     = (i_sp_op == SP_OP_POP) ? (i_raw_sp + ONE) : i_raw_sp;
    assign o_stack_depth = SP_RESET - i_raw_sp;

endmodule

// File: rtl/regfile_sp.sv
// General-purpose register file whose top register doubles as a bounds-checked stack pointer.
// Holds the register array, write port, write-first read muxes and write/stack arbitration.
module regfile_sp
    import regfile_sp_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                SP_IDX   = (2**ADDR_W) - 1,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(DEF_SP_RESET),
    parameter logic [DATA_W-1:0] SP_LIMIT = DATA_W'(DEF_SP_LIMIT)
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sp_if.slave bus
);

    localparam int                NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_IDX);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [DATA_W-1:0] w_raw_sp;
    logic [DATA_W-1:0] w_sp_next;
    logic [DATA_W-1:0] w_sp_addr;
    logic [DATA_W-1:0] w_stack_depth;
    logic              w_sp_wr;
    logic              w_sp_upd;
    logic              w_sp_ovf;
    logic              w_sp_unf;

    assign w_raw_sp = r_regs[SP_ADDR];
    // An explicit write to SP in the same cycle suppresses the stack op entirely.
    assign w_sp_wr  = bus.wr_en && (bus.wr_addr == SP_ADDR);

    sp_unit #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp_unit (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_raw_sp      (w_raw_sp),
        .i_sp_en       (bus.sp_en),
        .i_sp_op       (bus.sp_op),
        .i_sp_blocked  (w_sp_wr),
        .i_err_clr     (bus.err_clr),
        .o_sp_next     (w_sp_next),
        .o_sp_upd      (w_sp_upd),
        .o_sp_addr     (w_sp_addr),
        .o_stack_depth (w_stack_depth),
        .o_sp_ovf      (w_sp_ovf),
        .o_sp_unf      (w_sp_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            if (bus.wr_en) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end
            if (w_sp_upd) begin
                r_regs[SP_ADDR] <= w_sp_next;
            end
        end
    end

    always_comb begin
        bus.rd_data_a = r_regs[bus.rd_addr_a];
        bus.rd_data_b = r_regs[bus.rd_addr_b];
        if (bus.wr_en && (bus.rd_addr_a == bus.wr_addr)) begin
            bus.rd_data_a = bus.wr_data;
        end
        if (bus.wr_en && (bus.rd_addr_b == bus.wr_addr)) begin
            bus.rd_data_b = bus.wr_data;
        end
    end

    assign bus.sp_out      = w_sp_wr ? bus.wr_data : w_sp_next;
    assign bus.raw_sp      = w_raw_sp;
    assign bus.sp_addr     = w_sp_addr;
    assign bus.stack_depth = w_stack_depth;
    assign bus.sp_ovf      = w_sp_ovf;
    assign bus.sp_unf      = w_sp_unf;

endmodule

// File: tb/tb_regfile_sp.sv
// Scoreboard bench for regfile_sp: directed test-plan sequence followed by random traffic,
// expectations from an array-based reference model, compared by an independent monitor.
module tb_regfile_sp;
    import regfile_sp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sp_if bus ();

    regfile_sp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         tag;
        logic [7:0] rd_a;
        logic [7:0] rd_b;
        logic [7:0] sp_out;
        logic [7:0] raw_sp;
        logic [7:0] sp_addr;
        logic [7:0] depth;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t       exp_q[$];
    int         checks  = 0;
    int         errors  = 0;
    int         tag_ctr = 0;
    logic [7:0] m_regs [4];
    logic       m_ovf;
    logic       m_unf;

    task automatic check8(input string name, input int tag, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%02h, expected 0x%02h", name, tag, act, req);
        end
    endtask

    function automatic void m_reset();
        m_regs[0] = 8'h00;
        m_regs[1] = 8'h00;
        m_regs[2] = 8'h00;
        m_regs[3] = 8'hFE;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endfunction

    // Monitor: every negative edge with a pending expectation compares all observable outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check8("rd_data_a",   e.tag, bus.rd_data_a,   e.rd_a);
            check8("rd_data_b",   e.tag, bus.rd_data_b,   e.rd_b);
            check8("sp_out",      e.tag, bus.sp_out,      e.sp_out);
            check8("raw_sp",      e.tag, bus.raw_sp,      e.raw_sp);
            check8("sp_addr",     e.tag, bus.sp_addr,     e.sp_addr);
            check8("stack_depth", e.tag, bus.stack_depth, e.depth);
            check8("sp_ovf",      e.tag, {7'd0, bus.sp_ovf}, {7'd0, e.ovf});
            check8("sp_unf",      e.tag, {7'd0, bus.sp_unf}, {7'd0, e.unf});
        end
    end

    // One cycle of stimulus: drive, predict, queue the prediction, then advance the model.
    task automatic step(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic se, input logic so, input logic ec,
                        input logic [1:0] ra, input logic [1:0] rb, input bit rst_mid);
        exp_t       e;
        logic [7:0] sp;
        logic [7:0] nsp;
        bit         collide;
        bit         ovf_ev;
        bit         unf_ev;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.sp_en     = se;
        bus.sp_op     = so;
        bus.err_clr   = ec;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            m_reset();
        end
        sp      = m_regs[3];
        collide = we && (wa == 2'd3);
        ovf_ev  = se && !collide && (so == SP_OP_PUSH) && (sp == 8'h80);
        unf_ev  = se && !collide && (so == SP_OP_POP)  && (sp == 8'hFE);
        nsp     = sp;
        if (se && !collide && !ovf_ev && !unf_ev) begin
            nsp = (so == SP_OP_POP) ? sp + 8'd1 : sp - 8'd1;
        end
        e.tag     = tag_ctr;
        tag_ctr   = tag_ctr + 1;
        e.rd_a    = (we && ra == wa) ? wd : m_regs[ra];
        e.rd_b    = (we && rb == wa) ? wd : m_regs[rb];
        e.sp_out  = collide ? wd : nsp;
        e.raw_sp  = sp;
        e.sp_addr = (so == SP_OP_POP) ? sp + 8'd1 : sp;
        e.depth   = 8'hFE - sp;
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_mid) begin
            if (we) m_regs[wa] = wd;
            if (!collide) m_regs[3] = nsp;
            m_ovf = ovf_ev ? 1'b1 : (ec ? 1'b0 : m_ovf);
            m_unf = unf_ev ? 1'b1 : (ec ? 1'b0 : m_unf);
        end
        #1;
    endtask

    task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
        step(1'b0, 2'd0, 8'h00, 1'b0, SP_OP_PUSH, 1'b0, ra, rb, 1'b0);
    endtask

    task automatic push();
        step(1'b0, 2'd0, 8'h00, 1'b1, SP_OP_PUSH, 1'b0, 2'd3, 2'd0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 2'd0, 8'h00, 1'b1, SP_OP_POP, 1'b0, 2'd3, 2'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] wa, input logic [7:0] wd);
        step(1'b1, wa, wd, 1'b0, SP_OP_PUSH, 1'b0, wa, 2'd1, 1'b0);
    endtask

    initial begin
        logic       we, se, so, ec;
        logic [1:0] wa, ra, rb;
        logic [7:0] wd;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.sp_en     = 1'b0;
        bus.sp_op     = 1'b0;
        bus.err_clr   = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle(2'd0, 2'd1);
        idle(2'd2, 2'd3);

        wr(2'd0, 8'hAA);
        wr(2'd1, 8'hBB);
        wr(2'd2, 8'hCC);
        wr(2'd3, 8'hDD);
        idle(2'd0, 2'd1);
        idle(2'd2, 2'd3);

        step(1'b1, 2'd0, 8'h55, 1'b0, SP_OP_PUSH, 1'b0, 2'd0, 2'd1, 1'b0);
        step(1'b0, 2'd0, 8'hFF, 1'b0, SP_OP_PUSH, 1'b0, 2'd0, 2'd1, 1'b0);
        idle(2'd0, 2'd3);

        wr(2'd3, 8'hFE);
        push(); push(); push();
        pop(); pop(); pop();
        pop();
        step(1'b0, 2'd0, 8'h00, 1'b0, SP_OP_PUSH, 1'b1, 2'd3, 2'd0, 1'b0);
        idle(2'd3, 2'd0);

        wr(2'd3, 8'h80);
        push();
        idle(2'd3, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b1, SP_OP_PUSH, 1'b1, 2'd3, 2'd0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, SP_OP_PUSH, 1'b1, 2'd3, 2'd0, 1'b0);
        idle(2'd3, 2'd0);

        step(1'b1, 2'd3, 8'h40, 1'b1, SP_OP_PUSH, 1'b0, 2'd3, 2'd0, 1'b0);
        idle(2'd3, 2'd0);
        step(1'b1, 2'd3, 8'hFE, 1'b1, SP_OP_POP, 1'b0, 2'd3, 2'd0, 1'b0);

        push(); push();
        step(1'b0, 2'd0, 8'h00, 1'b1, SP_OP_PUSH, 1'b0, 2'd3, 2'd0, 1'b1);
        rst_n = 1'b1;
        idle(2'd3, 2'd0);

        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 99) < 25);
            wa = 2'($urandom_range(0, 3));
            wd = (wa == 2'd3) ? 8'($urandom_range(8'h80, 8'hFE)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) wd = (wa == 2'd3) ? 8'h81 : wd;
            se = ($urandom_range(0, 99) < 70);
            so = 1'($urandom_range(0, 1));
            ec = ($urandom_range(0, 99) < 10);
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            step(we, wa, wd, se, so, ec, ra, rb, ($urandom_range(0, 149) == 0));
            rst_n = 1'b1;
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
